// File: rtl/traffic_signal_actuated.sv
// Sensor-actuated four-way signal controller: NS/EW axes with optional protected left,
// min/max green with gap-out, and occupancy-extended all-stop clearance.
module traffic_signal_actuated #(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 16,
    parameter int LEFT_TIME  = 3,
    parameter int CLEAR_TIME = 2,
    parameter int CLEAR_MAX  = 8,
    parameter int LEFT_EN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sensor_light,
    input  logic [29:0] general_sensors,
    output logic [2:0]  outN,
    output logic [2:0]  outS,
    output logic [2:0]  outE,
    output logic [2:0]  outW,
    output logic [29:0] debug_port
);

    typedef enum logic [2:0] {
        ST_STARTUP  = 3'd0,
        ST_NS_LEFT  = 3'd1,
        ST_NS_GREEN = 3'd2,
        ST_NS_CLEAR = 3'd3,
        ST_EW_LEFT  = 3'd4,
        ST_EW_GREEN = 3'd5,
        ST_EW_CLEAR = 3'd6
    } state_t;

    localparam logic [2:0] C_STOP = 3'b000;
    localparam logic [2:0] C_LEFT = 3'b010;
    localparam logic [2:0] C_GO   = 3'b100;

    localparam longint CMAX = (64'd1 << CNT_W) - 1;

    if (CNT_W < 1 || CNT_W > 19 ||
        MIN_GREEN < 1 || MAX_GREEN < 1 || LEFT_TIME < 1 ||
        CLEAR_TIME < 1 || CLEAR_MAX < CLEAR_TIME ||
        longint'(MIN_GREEN - 1) > CMAX || longint'(MAX_GREEN - 1) > CMAX ||
        longint'(LEFT_TIME - 1) > CMAX || longint'(CLEAR_TIME - 1) > CMAX ||
        longint'(CLEAR_MAX - 1) > CMAX) begin : g_param_err
        $error("traffic_signal_actuated: timing parameter does not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] K_MIN  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] K_MAX  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] K_LEFT = CNT_W'(LEFT_TIME - 1);
    localparam logic [CNT_W-1:0] K_CLR  = CNT_W'(CLEAR_TIME - 1);
    localparam logic [CNT_W-1:0] K_CLRM = CNT_W'(CLEAR_MAX - 1);

    localparam state_t NS_ENTRY = (LEFT_EN != 0) ? ST_NS_LEFT : ST_NS_GREEN;
    localparam state_t EW_ENTRY = (LEFT_EN != 0) ? ST_EW_LEFT : ST_EW_GREEN;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_nsd;
    logic               w_ewd;
    logic               w_occ;
    logic               w_ns_exit;
    logic               w_ew_exit;
    logic               w_clr_done;
    logic               w_unused;

    assign w_nsd = sensor_light[4] | sensor_light[6];
    assign w_ewd = sensor_light[5] | sensor_light[7];
    assign w_occ = |sensor_light[3:0];

    // Green ends only if the opposing axis is waiting; otherwise rest in green.
    assign w_ns_exit  = w_ewd && ((r_cnt >= K_MIN && !w_nsd) || r_cnt >= K_MAX);
    assign w_ew_exit  = w_nsd && ((r_cnt >= K_MIN && !w_ewd) || r_cnt >= K_MAX);
    assign w_clr_done = (r_cnt >= K_CLR && !w_occ) || (r_cnt == K_CLRM);

    assign w_unused = ^general_sensors;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_STARTUP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_STARTUP:  if (r_cnt == K_CLR) w_next = (w_nsd || !w_ewd) ? NS_ENTRY : EW_ENTRY;
            ST_NS_LEFT:  if (r_cnt == K_LEFT) w_next = ST_NS_GREEN;
            ST_NS_GREEN: if (w_ns_exit) w_next = ST_NS_CLEAR;
            ST_NS_CLEAR: if (w_clr_done) w_next = EW_ENTRY;
            ST_EW_LEFT:  if (r_cnt == K_LEFT) w_next = ST_EW_GREEN;
            ST_EW_GREEN: if (w_ew_exit) w_next = ST_EW_CLEAR;
            ST_EW_CLEAR: if (w_clr_done) w_next = NS_ENTRY;
            default:     w_next = ST_STARTUP;
        endcase
    end

    always_comb begin
        outN = C_STOP;
        outS = C_STOP;
        outE = C_STOP;
        outW = C_STOP;
        case (r_state)
            ST_NS_LEFT:  begin outN = C_LEFT; outS = C_LEFT; end
            ST_NS_GREEN: begin outN = C_GO;   outS = C_GO;   end
            ST_EW_LEFT:  begin outE = C_LEFT; outW = C_LEFT; end
            ST_EW_GREEN: begin outE = C_GO;   outW = C_GO;   end
            default:     ;
        endcase
    end

    assign debug_port = 30'({r_cnt, r_state, sensor_light});

endmodule

// File: tb/tb_traffic_signal_actuated.sv
// Directed bench for traffic_signal_actuated plus a randomized invariant run on a
// LEFT_EN=0 instance.
module tb_traffic_signal_actuated;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic [7:0]  sl, sl2;
    logic [29:0] gs;
    logic [2:0]  outN, outS, outE, outW;
    logic [2:0]  nN, nS, nE, nW;
    logic [29:0] dbg, dbg2;

    traffic_signal_actuated u_dut (
        .clk(clk), .rst(rst), .sensor_light(sl), .general_sensors(gs),
        .outN(outN), .outS(outS), .outE(outE), .outW(outW), .debug_port(dbg)
    );

    traffic_signal_actuated #(.LEFT_EN(0)) u_dut_nl (
        .clk(clk), .rst(rst2), .sensor_light(sl2), .general_sensors(gs),
        .outN(nN), .outS(nS), .outE(nE), .outW(nW), .debug_port(dbg2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    function automatic int st();
        return int'(dbg[10:8]);
    endfunction

    function automatic int cnt();
        return int'(dbg[18:11]);
    endfunction

    function automatic int outs();
        return int'({outN, outS, outE, outW});
    endfunction

    // Counts consecutive negedge samples spent in state s (bounded).
    task automatic run_state(input int s, output int n);
        n = 0;
        while (st() == s && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n, bad;
    int bad_left, bad_cross, bad_dbg, bad_sens, n_ng, n_eg;

    initial begin
        rst = 1'b0; rst2 = 1'b0; sl = '0; sl2 = '0; gs = 30'h2AAA_5555;
        #12;
        chk("rst_outs", outs(), 0);
        chk("rst_state", st(), 0);
        chk("rst_cnt", cnt(), 0);

        // Startup with no demand: NS left then rest in NS green.
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("su_state", st(), 0);
        chk("su_outs", outs(), 0);
        @(negedge clk);
        chk("nsl_outs", outs(), {3'd2, 3'd2, 3'd0, 3'd0});
        run_state(1, n);
        chk("nsl_len", n, 3);
        chk("nsg_outs", outs(), {3'd4, 3'd4, 3'd0, 3'd0});
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (outs() != {3'd4, 3'd4, 3'd0, 3'd0}) bad++;
        end
        chk("rest_hold", bad, 0);
        repeat (260) @(negedge clk);
        chk("cnt_sat", cnt(), 255);
        chk("rest_state", st(), 2);
        chk("dbg_sens", int'(dbg[7:0]), int'(sl));

        // Max-out: continuous NS demand, EW arrives at green cnt=0.
        rst = 1'b0; sl = 8'h40;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk);
        run_state(1, n);
        chk("nsg_cnt0", cnt(), 0);
        sl = 8'h60;
        run_state(2, n);
        chk("maxout_len", n, 16);
        chk("nsc_outs", outs(), 0);
        run_state(3, n);
        chk("nsc_len", n, 2);
        chk("ewl_outs", outs(), {3'd0, 3'd0, 3'd2, 3'd2});
        sl = 8'h40;
        run_state(4, n);
        chk("ewl_len", n, 3);
        chk("ewg_outs", outs(), {3'd0, 3'd0, 3'd4, 3'd4});
        run_state(5, n);
        chk("ew_gapout_len", n, 4);

        // NS gap-out with EW demand only.
        sl = 8'h20;
        run_state(6, n);
        chk("ewc_len", n, 2);
        run_state(1, n);
        run_state(2, n);
        chk("ns_gapout_len", n, 4);

        // Clearance held to CLEAR_MAX by occupancy.
        sl = 8'h41;
        run_state(3, n);
        chk("clrmax_len", n, 8);
        chk("clrmax_exit", st(), 4);
        run_state(4, n);
        run_state(5, n);
        chk("ew_gapout2_len", n, 4);
        repeat (3) @(negedge clk);
        chk("clr_cnt3", cnt(), 3);
        chk("clr_state", st(), 6);
        sl = 8'h40;
        @(negedge clk);
        chk("clr_drop_exit", st(), 1);
        chk("clr_drop_outs", outs(), {3'd2, 3'd2, 3'd0, 3'd0});

        // Async reset in the middle of EW green.
        sl = 8'h20;
        run_state(1, n);
        run_state(2, n);
        run_state(3, n);
        run_state(4, n);
        repeat (2) @(negedge clk);
        chk("ewg_before_rst", st(), 5);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outs", outs(), 0);
        chk("async_rst_state", st(), 0);
        sl = 8'h00;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rerun_su", st(), 0);
        @(negedge clk);
        chk("rerun_nsl", outs(), {3'd2, 3'd2, 3'd0, 3'd0});

        // LEFT_EN=0 instance under random sensors.
        bad_left = 0; bad_cross = 0; bad_dbg = 0; bad_sens = 0; n_ng = 0; n_eg = 0;
        @(negedge clk); rst2 = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (nN == 3'd2 || nS == 3'd2 || nE == 3'd2 || nW == 3'd2) bad_left++;
            if ((nN != 0 || nS != 0) && (nE != 0 || nW != 0)) bad_cross++;
            case (dbg2[10:8])
                3'd2:    begin n_ng++; if ({nN, nS, nE, nW} != {3'd4, 3'd4, 3'd0, 3'd0}) bad_dbg++; end
                3'd5:    begin n_eg++; if ({nN, nS, nE, nW} != {3'd0, 3'd0, 3'd4, 3'd4}) bad_dbg++; end
                3'd0, 3'd3, 3'd6: if ({nN, nS, nE, nW} != 12'd0) bad_dbg++;
                default: bad_dbg++;
            endcase
            if (dbg2[7:0] != sl2 || dbg2[29:19] != '0) bad_sens++;
            sl2 = 8'($urandom);
        end
        chk("nl_no_left", bad_left, 0);
        chk("nl_no_cross", bad_cross, 0);
        chk("nl_dbg_state", bad_dbg, 0);
        chk("nl_dbg_sens", bad_sens, 0);
        chk("nl_ns_served", int'(n_ng > 0), 1);
        chk("nl_ew_served", int'(n_eg > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/traffic_signal_actuated.md
Name: traffic_signal_actuated

Overview:
- Parametrised, sensor-actuated four-way signal controller for one intersection.
- Successor to the fixed-output light modules; drives outN/outS/outE/outW with the standard 3-bit signal codes.
- Alternates NS and EW axes with min/max green, gap-out on no demand, all-stop clearance extended while the box is occupied, and an optional protected-left phase per axis.
- Rests in green on the active axis when the other axis has no demand.

Parameters:
- CNT_W, 8, phase counter width (1..19).
- MIN_GREEN, 4, minimum cycles in a green phase.
- MAX_GREEN, 16, green cycles after which a waiting opposing axis is served.
- LEFT_TIME, 3, cycles of a protected-left phase.
- CLEAR_TIME, 2, minimum all-stop clearance cycles.
- CLEAR_MAX, 8, clearance cycle cap, reached even while occupied (CLEAR_MAX >= CLEAR_TIME).
- LEFT_EN, 1, 1 inserts a protected-left phase before each axis green.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sensor_light  in  8  light sensors: [4] southbound queue, [6] northbound, [5] eastbound, [7] westbound, [3:0] intersection box occupancy
- general_sensors  in  30  user sensors; reserved, ignored by logic
- outN  out  3  signal code for northbound traffic
- outS  out  3  signal code for southbound traffic
- outE  out  3  signal code for eastbound traffic
- outW  out  3  signal code for westbound traffic
- debug_port  out  30  {zeros, cnt, state[2:0], sensor_light[7:0]}; cnt occupies [CNT_W+10:11]

Behaviour:
- Signal codes: Stop=000, Forward_only=001, Left_only=010, Right_only=011, Go=100.
- Demand definitions: nsd = s[4]|s[6]; ewd = s[5]|s[7]; occ = |s[3:0].
- States: STARTUP=0, NS_LEFT=1, NS_GREEN=2, NS_CLEAR=3, EW_LEFT=4, EW_GREEN=5, EW_CLEAR=6.
- Output decode from the state register (outputs change in the same cycle as the state):
  - STARTUP and CLEAR states: all Stop.
  - NS_LEFT: outN=outS=Left_only, E/W Stop.
  - NS_GREEN: outN=outS=Go, E/W Stop.
  - EW_LEFT / EW_GREEN: mirror image of the NS states.
- Reset (rst=0): state=STARTUP, cnt=0, all outputs Stop, asynchronously. A mid-phase reset abandons the phase immediately.
- Counter: cnt clears on every state change and increments by one each cycle otherwise, saturating at all-ones.
- STARTUP: when cnt==CLEAR_TIME-1, go to the NS axis if nsd or !ewd, else to the EW axis.
  - Axis entry means the axis LEFT state if LEFT_EN, else the axis GREEN state.
- NS_LEFT: when cnt==LEFT_TIME-1, go to NS_GREEN. Sensors are not sampled in this phase.
- NS_GREEN: exit to NS_CLEAR on the edge where ewd=1 and either:
  - gap-out: cnt>=MIN_GREEN-1 and nsd=0; or
  - max-out: cnt>=MAX_GREEN-1 regardless of nsd.
  - With ewd=0 the phase holds indefinitely (rest in green), and cnt saturates.
- NS_CLEAR: leave when (cnt>=CLEAR_TIME-1 and occ=0) or cnt==CLEAR_MAX-1.
  - Exit goes to EW axis entry, always; the axis alternates even if ewd dropped during clearance.
- EW_LEFT, EW_GREEN, EW_CLEAR: symmetric with the NS states; EW_CLEAR exits to NS axis entry.
- All comparisons are unsigned at CNT_W bits. Every parameter minus 1 must fit in CNT_W, which is checked by an elaboration-time assertion.
- Simultaneous events:
  - nsd and ewd rising in the same cycle during STARTUP selects NS.
  - In green, gap-out and max-out are the same transition.
- No output combination ever gives Go/Forward/Left to crossing axes. No direct GREEN->GREEN transition exists; a CLEAR state always intervenes.
- Illegal state encoding (7): next state STARTUP.

Test Plan:
- Reset release, no sensors, LEFT_EN=1, CLEAR_TIME=2, LEFT_TIME=3 -> 2 cycles all Stop; 3 cycles outN=outS=010; then outN=outS=100 held 50 cycles.
- NS_GREEN with s[6]=1 continuously, s[5] asserted at cnt=0, MAX_GREEN=16 -> exit after exactly 16 green cycles; NS_CLEAR; then EW_LEFT with outE=outW=010.
- NS_GREEN with s[5]=1, nsd=0 from cnt=0, MIN_GREEN=4 -> green lasts 4 cycles, then clearance.
- NS_CLEAR with s[0]=1 held, CLEAR_MAX=8 -> all Stop for 8 cycles, then EW entry. Dropping s[0] at cnt=3 -> exit after 4 cycles.
- Assert rst=0 mid EW_GREEN -> outputs Stop immediately without waiting for a clk edge; STARTUP sequence repeats on release.
- LEFT_EN=0 with random sensors over 10k cycles -> no Left_only codes ever; crossing axes never non-Stop together; debug_port[10:8] matches the state and [7:0] equals sensor_light.
